// File: rtl/snitch_icache_miss_handler.sv
// -----------------------------------------------------------------------------
// snitch_icache_miss_handler
//
// Purpose:
//   Consumes registered icache lookup results. Hits are returned to the fetch
//   side through a one-entry response register. Misses allocate a pending
//   entry that walks FREE -> REQ -> WAIT -> WRITE -> RESP -> FREE. Along the
//   way it issues a line refill, captures the returned line, writes it back
//   into the lookup stage and answers every requestor merged onto that miss.
//
// Optional feature:
//   SNITCH_ICACHE_MISS_MERGE_EN
//     Defined:   a secondary miss to a line that is already in REQ/WAIT is
//                accepted immediately and its ID is OR-ed into the entry mask.
//     Undefined: such a miss is stalled (in_ready_o=0) until the entry frees.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   in_*                            lookup result (addr, id, set, hit, data,
//                                   error, valid/ready)
//   rsp_*                           response to fetch (data, error, id mask,
//                                   valid/ready)
//   refill_addr/id/valid_o, ready_i refill request
//   refill_data/error/id/valid_i,
//   refill_ready_o                  refill response
//   write_*                         line write-back into the lookup stage
// -----------------------------------------------------------------------------
module snitch_icache_miss_handler #(
  parameter int FETCH_AW      = 32,
  parameter int ID_WIDTH      = 4,
  parameter int LINE_WIDTH    = 128,
  parameter int LINE_ALIGN    = 4,
  parameter int COUNT_ALIGN   = 5,
  parameter int SET_COUNT     = 2,
  parameter int SET_ALIGN     = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
  parameter int TAG_WIDTH     = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
  parameter int PENDING_COUNT = 2,
  parameter int PENDING_IW    = (PENDING_COUNT > 1) ? $clog2(PENDING_COUNT) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [FETCH_AW-1:0]    in_addr_i,
  input  logic [ID_WIDTH-1:0]    in_id_i,
  input  logic [SET_ALIGN-1:0]   in_set_i,
  input  logic                   in_hit_i,
  input  logic [LINE_WIDTH-1:0]  in_data_i,
  input  logic                   in_error_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [LINE_WIDTH-1:0]  rsp_data_o,
  output logic                   rsp_error_o,
  output logic [ID_WIDTH-1:0]    rsp_id_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [FETCH_AW-1:0]    refill_addr_o,
  output logic [PENDING_IW-1:0]  refill_id_o,
  output logic                   refill_valid_o,
  input  logic                   refill_ready_i,
  input  logic [LINE_WIDTH-1:0]  refill_data_i,
  input  logic                   refill_error_i,
  input  logic [PENDING_IW-1:0]  refill_id_i,
  input  logic                   refill_valid_i,
  output logic                   refill_ready_o,
  output logic [COUNT_ALIGN-1:0] write_addr_o,
  output logic [SET_ALIGN-1:0]   write_set_o,
  output logic [LINE_WIDTH-1:0]  write_data_o,
  output logic [TAG_WIDTH-1:0]   write_tag_o,
  output logic                   write_error_o,
  output logic                   write_valid_o,
  input  logic                   write_ready_i
);

  typedef enum logic [2:0] {E_FREE, E_REQ, E_WAIT, E_WRITE, E_RESP} entry_state_e;

  localparam logic [FETCH_AW-1:0] LINE_MASK =
    {{(FETCH_AW-LINE_ALIGN){1'b1}}, {LINE_ALIGN{1'b0}}};

  entry_state_e           state_reg  [PENDING_COUNT];
  entry_state_e           state_next [PENDING_COUNT];
  logic [FETCH_AW-1:0]    addr_reg   [PENDING_COUNT];
  logic [ID_WIDTH-1:0]    id_reg     [PENDING_COUNT];
  logic [LINE_WIDTH-1:0]  data_reg   [PENDING_COUNT];
  logic [PENDING_COUNT-1:0] error_reg;
  // older_reg[i][j] = 1 when entry i was allocated before entry j
  logic [PENDING_COUNT-1:0] older_reg [PENDING_COUNT];

  logic                   hit_valid_reg, hit_error_reg;
  logic [ID_WIDTH-1:0]    hit_id_reg;
  logic [LINE_WIDTH-1:0]  hit_data_reg;
  logic [SET_ALIGN-1:0]   victim_reg;

  logic [FETCH_AW-1:0]    in_line;
  logic                   match_pend, match_busy, free_any, resp_any, wr_any, req_any;
  logic [PENDING_IW-1:0]  match_idx, free_idx, resp_idx, wr_idx, req_idx;
  logic                   hit_ready, miss_ready, accept, hit_load, alloc;
  logic                   refill_req_fire, refill_rsp_fire, write_fire;
  logic                   entry_rsp_fire, hit_rsp_fire;
  logic                   unused_ok;

  assign unused_ok = ^in_set_i;
  assign in_line   = in_addr_i & LINE_MASK;

  // Entry lookups. Selection loops run downward so the lowest index wins.
  always_comb begin
    match_pend = 1'b0; match_busy = 1'b0; match_idx = '0;
    free_any   = 1'b0; free_idx   = '0;
    resp_any   = 1'b0; resp_idx   = '0;
    wr_any     = 1'b0; wr_idx     = '0;
    req_any    = 1'b0; req_idx    = '0;
    for (int i = PENDING_COUNT - 1; i >= 0; i--) begin
      if (addr_reg[i] == in_line) begin
        if (state_reg[i] == E_REQ || state_reg[i] == E_WAIT) begin
          match_pend = 1'b1; match_idx = PENDING_IW'(i);
        end
        if (state_reg[i] == E_WRITE || state_reg[i] == E_RESP) match_busy = 1'b1;
      end
      if (state_reg[i] == E_FREE)  begin free_any = 1'b1; free_idx = PENDING_IW'(i); end
      if (state_reg[i] == E_RESP)  begin resp_any = 1'b1; resp_idx = PENDING_IW'(i); end
      if (state_reg[i] == E_WRITE) begin wr_any   = 1'b1; wr_idx   = PENDING_IW'(i); end
    end
    // Oldest REQ entry: a REQ entry older than every other REQ entry.
    for (int i = PENDING_COUNT - 1; i >= 0; i--) begin
      logic oldest;
      oldest = (state_reg[i] == E_REQ);
      for (int j = 0; j < PENDING_COUNT; j++) begin
        if (j != i && state_reg[j] == E_REQ && !older_reg[i][j]) oldest = 1'b0;
      end
      if (oldest) begin req_any = 1'b1; req_idx = PENDING_IW'(i); end
    end
  end

  // The hit register may only be reloaded if its content leaves this cycle,
  // which cannot happen while a RESP entry owns the response port.
  assign hit_ready = (!hit_valid_reg || rsp_ready_i) && !resp_any;

  always_comb begin
    miss_ready = free_any;
    if (match_busy) begin
      miss_ready = 1'b0;
    end else if (match_pend) begin
`ifdef SNITCH_ICACHE_MISS_MERGE_EN
      miss_ready = 1'b1;
`else
      miss_ready = 1'b0;
`endif
    end
  end

  // Held low during reset so nothing is accepted while state is cleared.
  assign in_ready_o = !rst_i && (in_hit_i ? hit_ready : miss_ready);
  assign accept     = in_valid_i && in_ready_o;
  assign hit_load   = accept && in_hit_i;
  assign alloc      = accept && !in_hit_i && !match_pend;

  // Refill request / response
  assign refill_valid_o  = req_any;
  assign refill_addr_o   = req_any ? addr_reg[req_idx] : '0;
  assign refill_id_o     = req_any ? req_idx : '0;
  assign refill_ready_o  = (int'(refill_id_i) < PENDING_COUNT) &&
                           (state_reg[refill_id_i] == E_WAIT);
  assign refill_req_fire = req_any && refill_ready_i;
  assign refill_rsp_fire = refill_valid_i && refill_ready_o;

  // Write-back
  assign write_valid_o = wr_any;
  assign write_addr_o  = wr_any ? addr_reg[wr_idx][LINE_ALIGN +: COUNT_ALIGN] : '0;
  assign write_tag_o   = wr_any ? addr_reg[wr_idx][FETCH_AW-1 -: TAG_WIDTH] : '0;
  assign write_set_o   = wr_any ? victim_reg : '0;
  assign write_data_o  = wr_any ? data_reg[wr_idx] : '0;
  assign write_error_o = wr_any && error_reg[wr_idx];
  assign write_fire    = wr_any && write_ready_i;

  // Response: a RESP entry takes precedence over the hit register
  assign rsp_valid_o    = resp_any || hit_valid_reg;
  assign rsp_data_o     = resp_any ? data_reg[resp_idx] : (hit_valid_reg ? hit_data_reg : '0);
  assign rsp_id_o       = resp_any ? id_reg[resp_idx]   : (hit_valid_reg ? hit_id_reg : '0);
  assign rsp_error_o    = resp_any ? error_reg[resp_idx] : (hit_valid_reg && hit_error_reg);
  assign entry_rsp_fire = rsp_ready_i && resp_any;
  assign hit_rsp_fire   = rsp_ready_i && !resp_any && hit_valid_reg;

  // Entry state transitions; each event targets a distinct source state.
  always_comb begin
    for (int i = 0; i < PENDING_COUNT; i++) begin
      state_next[i] = state_reg[i];
      if (alloc && free_idx == PENDING_IW'(i))              state_next[i] = E_REQ;
      if (refill_req_fire && req_idx == PENDING_IW'(i))     state_next[i] = E_WAIT;
      if (refill_rsp_fire && refill_id_i == PENDING_IW'(i)) state_next[i] = E_WRITE;
      if (write_fire && wr_idx == PENDING_IW'(i))           state_next[i] = E_RESP;
      if (entry_rsp_fire && resp_idx == PENDING_IW'(i))     state_next[i] = E_FREE;
    end
  end

  for (genvar gi = 0; gi < PENDING_COUNT; gi++) begin : g_entry
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_reg[gi]     <= E_FREE;
        addr_reg[gi]      <= '0;
        id_reg[gi]        <= '0;
        data_reg[gi]      <= '0;
        error_reg[gi]     <= 1'b0;
        older_reg[gi]     <= '0;
      end else begin
        state_reg[gi] <= state_next[gi];
        if (alloc) begin
          if (free_idx == PENDING_IW'(gi)) begin
            addr_reg[gi]  <= in_line;
            id_reg[gi]    <= in_id_i;
            older_reg[gi] <= '0;
          end else begin
            older_reg[gi][free_idx] <= 1'b1;
          end
        end
`ifdef SNITCH_ICACHE_MISS_MERGE_EN
        if (accept && !in_hit_i && match_pend && match_idx == PENDING_IW'(gi))
          id_reg[gi] <= id_reg[gi] | in_id_i;
`endif
        if (refill_rsp_fire && refill_id_i == PENDING_IW'(gi)) begin
          data_reg[gi]  <= refill_data_i;
          error_reg[gi] <= refill_error_i;
        end
      end
    end
  end

`ifndef SNITCH_ICACHE_MISS_MERGE_EN
  logic unused_match_idx;
  assign unused_match_idx = ^match_idx;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_valid_reg <= 1'b0;
      hit_error_reg <= 1'b0;
      hit_id_reg    <= '0;
      hit_data_reg  <= '0;
      victim_reg    <= '0;
    end else begin
      if (hit_load) begin
        hit_valid_reg <= 1'b1;
        hit_error_reg <= in_error_i;
        hit_id_reg    <= in_id_i;
        hit_data_reg  <= in_data_i;
      end else if (hit_rsp_fire) begin
        hit_valid_reg <= 1'b0;
      end
      if (write_fire)
        victim_reg <= (victim_reg == SET_ALIGN'(SET_COUNT - 1)) ? '0 : victim_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_snitch_icache_miss_handler.sv
// -----------------------------------------------------------------------------
// tb_snitch_icache_miss_handler
//
// Directed bench for snitch_icache_miss_handler with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked one
// further time unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_snitch_icache_miss_handler;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  in_addr_i = '0;
  logic [3:0]   in_id_i = '0;
  logic [0:0]   in_set_i = '0;
  logic         in_hit_i = 1'b0;
  logic [127:0] in_data_i = '0;
  logic         in_error_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [127:0] rsp_data_o;
  logic         rsp_error_o;
  logic [3:0]   rsp_id_o;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b1;
  logic [31:0]  refill_addr_o;
  logic [0:0]   refill_id_o;
  logic         refill_valid_o;
  logic         refill_ready_i = 1'b0;
  logic [127:0] refill_data_i = '0;
  logic         refill_error_i = 1'b0;
  logic [0:0]   refill_id_i = '0;
  logic         refill_valid_i = 1'b0;
  logic         refill_ready_o;
  logic [4:0]   write_addr_o;
  logic [0:0]   write_set_o;
  logic [127:0] write_data_o;
  logic [22:0]  write_tag_o;
  logic         write_error_o;
  logic         write_valid_o;
  logic         write_ready_i = 1'b0;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D0   = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] D1   = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D2   = 128'hdeadbeef_cafef00d_01020304_05060708;
  localparam logic [127:0] D3   = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] D4   = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;
  localparam logic [127:0] DH   = 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0;

  always #5 clk_i = ~clk_i;

  snitch_icache_miss_handler dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_addr_i(in_addr_i), .in_id_i(in_id_i), .in_set_i(in_set_i),
    .in_hit_i(in_hit_i), .in_data_i(in_data_i), .in_error_i(in_error_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o), .rsp_id_o(rsp_id_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .refill_addr_o(refill_addr_o), .refill_id_o(refill_id_o),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_data_i(refill_data_i), .refill_error_i(refill_error_i),
    .refill_id_i(refill_id_i), .refill_valid_i(refill_valid_i),
    .refill_ready_o(refill_ready_o),
    .write_addr_o(write_addr_o), .write_set_o(write_set_o),
    .write_data_o(write_data_o), .write_tag_o(write_tag_o),
    .write_error_o(write_error_o), .write_valid_o(write_valid_o),
    .write_ready_i(write_ready_i)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    #1 rst_i = 1'b1;
    #2;
    check_val("rst_rsp_valid",    rsp_valid_o, 0);
    check_val("rst_refill_valid", refill_valid_o, 0);
    check_val("rst_write_valid",  write_valid_o, 0);
    check_val("rst_refill_ready", refill_ready_o, 0);
    check_val("rst_in_ready",     in_ready_o, 0);
    check_val("rst_rsp_data",     rsp_data_o, 0);
    check_val("rst_refill_addr",  refill_addr_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1 rst_i = 1'b0;

    // ---------------- hit ----------------
    in_valid_i = 1; in_hit_i = 1; in_addr_i = 32'h100; in_id_i = 4'b0001; in_data_i = D_A5;
    #1 check_val("hit_in_ready", in_ready_o, 1);
    tick(); in_valid_i = 0; in_hit_i = 0;
    #1;
    check_val("hit_rsp_valid", rsp_valid_o, 1);
    check_val("hit_rsp_id",    rsp_id_o, 4'b0001);
    check_val("hit_rsp_data",  rsp_data_o, D_A5);
    check_val("hit_rsp_error", rsp_error_o, 0);
    tick(); #1 check_val("hit_rsp_done", rsp_valid_o, 0);

    // ---------------- single miss 0x1234 ----------------
    in_valid_i = 1; in_hit_i = 0; in_addr_i = 32'h1234; in_id_i = 4'b0010;
    #1 check_val("miss_in_ready", in_ready_o, 1);
    tick(); in_valid_i = 0;
    #1;
    check_val("miss_refill_valid", refill_valid_o, 1);
    check_val("miss_refill_addr",  refill_addr_o, 32'h1230);
    check_val("miss_refill_id",    refill_id_o, 0);
    tick(); #1;
    check_val("miss_refill_stall_valid", refill_valid_o, 1);
    check_val("miss_refill_stall_addr",  refill_addr_o, 32'h1230);
    refill_ready_i = 1; tick(); refill_ready_i = 0;
    #1 check_val("miss_refill_done", refill_valid_o, 0);
    refill_id_i = 0; refill_valid_i = 1; refill_data_i = D0;
    #1 check_val("miss_refill_ready", refill_ready_o, 1);
    tick(); refill_valid_i = 0;
    #1;
    check_val("miss_write_valid", write_valid_o, 1);
    check_val("miss_write_addr",  write_addr_o, 5'h03);
    check_val("miss_write_tag",   write_tag_o, 23'h9);
    check_val("miss_write_set",   write_set_o, 0);
    check_val("miss_write_data",  write_data_o, D0);
    check_val("miss_write_error", write_error_o, 0);
    check_val("miss_no_rsp_yet",  rsp_valid_o, 0);
    write_ready_i = 1; tick(); write_ready_i = 0;
    #1;
    check_val("miss_rsp_valid", rsp_valid_o, 1);
    check_val("miss_rsp_id",    rsp_id_o, 4'b0010);
    check_val("miss_rsp_data",  rsp_data_o, D0);
    tick(); #1 check_val("miss_rsp_done", rsp_valid_o, 0);

    // ---------------- pending capacity ----------------
    in_valid_i = 1; in_hit_i = 0; in_addr_i = 32'h1000; in_id_i = 4'b0001;
    #1 check_val("cap_first_ready", in_ready_o, 1);
    tick(); in_addr_i = 32'h2000; in_id_i = 4'b0010;
    #1 check_val("cap_second_ready", in_ready_o, 1);
    tick(); in_addr_i = 32'h3000; in_id_i = 4'b0100;
    #1;
    check_val("cap_third_stall", in_ready_o, 0);
    check_val("cap_refill_id0",   refill_id_o, 0);
    check_val("cap_refill_addr0", refill_addr_o, 32'h1000);
    refill_ready_i = 1; tick();
    #1;
    check_val("cap_refill_id1",   refill_id_o, 1);
    check_val("cap_refill_addr1", refill_addr_o, 32'h2000);
    tick(); refill_ready_i = 0;
    #1;
    check_val("cap_refills_done", refill_valid_o, 0);
    check_val("cap_still_stall",  in_ready_o, 0);
    refill_id_i = 0; refill_valid_i = 1; refill_data_i = D1;
    tick(); refill_valid_i = 0;
    #1;
    check_val("cap_write_valid", write_valid_o, 1);
    check_val("cap_write_set",   write_set_o, 1);
    check_val("cap_write_addr",  write_addr_o, 5'h00);
    check_val("cap_write_tag",   write_tag_o, 23'h8);
    check_val("cap_stall_write", in_ready_o, 0);
    write_ready_i = 1; rsp_ready_i = 0; tick(); write_ready_i = 0;
    #1;
    check_val("cap_rsp_valid",   rsp_valid_o, 1);
    check_val("cap_rsp_id",      rsp_id_o, 4'b0001);
    check_val("cap_rsp_data",    rsp_data_o, D1);
    check_val("cap_stall_resp",  in_ready_o, 0);
    rsp_ready_i = 1; tick();
    #1;
    check_val("cap_third_ready", in_ready_o, 1);
    check_val("cap_rsp_gone",    rsp_valid_o, 0);
    tick(); in_valid_i = 0;
    #1;
    check_val("cap_third_refill_valid", refill_valid_o, 1);
    check_val("cap_third_refill_id",    refill_id_o, 0);
    check_val("cap_third_refill_addr",  refill_addr_o, 32'h3000);
    refill_ready_i = 1; tick(); refill_ready_i = 0;
    refill_id_i = 1; refill_valid_i = 1; refill_data_i = D2;
    tick(); refill_valid_i = 0;
    #1 check_val("cap_e1_write_set", write_set_o, 0);
    write_ready_i = 1; tick(); write_ready_i = 0;
    #1;
    check_val("cap_e1_rsp_id",   rsp_id_o, 4'b0010);
    check_val("cap_e1_rsp_data", rsp_data_o, D2);
    tick();

    // ---------------- refill error with a hit waiting ----------------
    refill_id_i = 0; refill_valid_i = 1; refill_data_i = D3; refill_error_i = 1;
    tick(); refill_valid_i = 0; refill_error_i = 0;
    #1;
    check_val("err_write_valid", write_valid_o, 1);
    check_val("err_write_error", write_error_o, 1);
    check_val("err_write_set",   write_set_o, 1);
    in_valid_i = 1; in_hit_i = 1; in_addr_i = 32'h200; in_id_i = 4'b1000; in_data_i = DH;
    rsp_ready_i = 0;
    #1 check_val("err_hit_ready", in_ready_o, 1);
    tick(); in_valid_i = 0; in_hit_i = 0;
    #1 check_val("err_hit_rsp_id", rsp_id_o, 4'b1000);
    write_ready_i = 1; tick(); write_ready_i = 0;
    #1;
    check_val("err_entry_rsp_id",    rsp_id_o, 4'b0100);
    check_val("err_entry_rsp_error", rsp_error_o, 1);
    check_val("err_entry_rsp_data",  rsp_data_o, D3);
    rsp_ready_i = 1; tick();
    #1;
    check_val("err_hit_after_valid", rsp_valid_o, 1);
    check_val("err_hit_after_id",    rsp_id_o, 4'b1000);
    check_val("err_hit_after_data",  rsp_data_o, DH);
    check_val("err_hit_after_error", rsp_error_o, 0);
    tick(); #1 check_val("err_all_done", rsp_valid_o, 0);

    // ---------------- secondary miss ----------------
    in_valid_i = 1; in_hit_i = 0; in_addr_i = 32'h40; in_id_i = 4'b0001;
    #1 check_val("sec_first_ready", in_ready_o, 1);
    tick(); in_addr_i = 32'h48; in_id_i = 4'b0100;
    #1;
`ifdef SNITCH_ICACHE_MISS_MERGE_EN
    check_val("sec_merge_ready", in_ready_o, 1);
    tick();
`else
    check_val("sec_stall_ready", in_ready_o, 0);
`endif
    in_valid_i = 0;
    #1;
    check_val("sec_refill_id",   refill_id_o, 0);
    check_val("sec_refill_addr", refill_addr_o, 32'h40);
    refill_ready_i = 1; tick(); refill_ready_i = 0;
    #1 check_val("sec_single_refill", refill_valid_o, 0);
    refill_id_i = 0; refill_valid_i = 1; refill_data_i = D4;
    tick(); refill_valid_i = 0;
    write_ready_i = 1; tick(); write_ready_i = 0;
    #1;
    check_val("sec_rsp_valid", rsp_valid_o, 1);
`ifdef SNITCH_ICACHE_MISS_MERGE_EN
    check_val("sec_rsp_id", rsp_id_o, 4'b0101);
`else
    check_val("sec_rsp_id", rsp_id_o, 4'b0001);
`endif
    check_val("sec_rsp_data", rsp_data_o, D4);
    tick();

    // ---------------- asynchronous reset mid-operation ----------------
    in_valid_i = 1; in_hit_i = 0; in_addr_i = 32'h500; in_id_i = 4'b0010;
    tick(); in_addr_i = 32'h600; in_id_i = 4'b0001;
    tick(); in_valid_i = 0;
    refill_ready_i = 1; tick(); tick(); refill_ready_i = 0;
    refill_id_i = 1; refill_valid_i = 1; refill_data_i = D0;
    tick(); refill_valid_i = 0;
    #1;
    check_val("ar_pre_write_valid", write_valid_o, 1);
    check_val("ar_pre_write_set",   write_set_o, 1);
    refill_id_i = 0; refill_valid_i = 1; refill_data_i = D1;
    #1 rst_i = 1'b1;
    #1;
    check_val("ar_write_valid",  write_valid_o, 0);
    check_val("ar_refill_ready", refill_ready_o, 0);
    check_val("ar_refill_valid", refill_valid_o, 0);
    check_val("ar_rsp_valid",    rsp_valid_o, 0);
    check_val("ar_in_ready",     in_ready_o, 0);
    check_val("ar_write_data",   write_data_o, 0);
    tick(); rst_i = 1'b0;
    #1 check_val("ar_post_refill_ready", refill_ready_o, 0);
    tick();
    #1;
    check_val("ar_post2_refill_ready", refill_ready_o, 0);
    check_val("ar_post_write_valid",   write_valid_o, 0);
    check_val("ar_post_rsp_valid",     rsp_valid_o, 0);
    refill_valid_i = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
